param_mem: RTL and testbench

Parametrised single-port synchronous memory: the successor to the fixed 32×8 memory, generalised in address/data width, depth and read latency. It adds a hardware clear-on-reset sequence, a ready/rvalid handshake and out-of-range detection. It sits behind `mem_interface`-style testbench tasks and behind design-side masters that drive `read`/`write` strobes.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_array.sv | 37 +++
 rtl/param_mem.sv | 144 ++++++++++++++
 tb/tb_param_mem.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and elaboration-time parameter checks for the parametrised memory.
package mem_pkg;

    typedef enum logic [0:0] {
        CLEAR,
        RUN
    } mem_state_t;

    localparam int unsigned MIN_READ_LATENCY = 1;
    localparam int unsigned MAX_READ_LATENCY = 2;

    function automatic bit latency_ok(input int unsigned lat);
        return (lat >= MIN_READ_LATENCY) && (lat <= MAX_READ_LATENCY);
    endfunction

    function automatic bit params_ok(input int unsigned lat, input int unsigned depth,
                                     input int unsigned addr_width);
        return latency_ok(lat) && (depth >= 1) &&
               (longint'(depth) <= (longint'(1) << addr_width));
    endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_WIDTH storage: one write port and one registered read port.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned IDX_WIDTH  = 5,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic                  rzero,
    input  logic [IDX_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rzero forces the out-of-range response value without touching the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rzero ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/param_mem.sv
// Parametrised single-port memory with clear-on-reset sweep, ready/rvalid handshake
// and out-of-range error reporting.
module param_mem
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ready,
    output logic                  rvalid,
    output logic                  err,
    output logic                  busy
);

    localparam int unsigned IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    if (!params_ok(READ_LATENCY, DEPTH, ADDR_WIDTH)) begin : g_bad_params
        $error("param_mem: illegal READ_LATENCY/DEPTH/ADDR_WIDTH combination");
    end

    mem_state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q;

    logic in_range, acc_rd, acc_wr, clr_last;
    logic arr_we;
    logic [IDX_WIDTH-1:0]  arr_waddr;
    logic [DATA_WIDTH-1:0] arr_wdata, arr_rdata;

    logic rv1_q, rerr1_q, werr_q;
    logic rd_valid, rd_err;

    assign in_range = {1'b0, addr} < DEPTH_W;
    assign ready    = (state_q == RUN);
    assign busy     = (state_q == CLEAR);
    assign acc_rd   = ready && read && !write;
    assign acc_wr   = ready && write && !read;
    assign clr_last = (clr_ptr_q == LAST_PTR);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEAR:   if (clr_last) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) begin
                clr_ptr_q <= clr_ptr_q + ADDR_WIDTH'(1);
            end
        end
    end

    // The sweep owns the write port while busy; out-of-range writes never reach the array.
    always_comb begin
        arr_we    = acc_wr && in_range;
        arr_waddr = addr[IDX_WIDTH-1:0];
        arr_wdata = data_in;
        if (busy) begin
            arr_we    = 1'b1;
            arr_waddr = clr_ptr_q[IDX_WIDTH-1:0];
            arr_wdata = CLEAR_VALUE;
        end
    end

    mem_array #(
        .IDX_WIDTH  (IDX_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (acc_rd),
        .rzero (!in_range),
        .raddr (addr[IDX_WIDTH-1:0]),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rv1_q   <= 1'b0;
            rerr1_q <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            rv1_q   <= acc_rd;
            rerr1_q <= acc_rd && !in_range;
            werr_q  <= acc_wr && !in_range;
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign rd_valid = rv1_q;
        assign rd_err   = rerr1_q;
        assign data_out = arr_rdata;
    end else begin : g_lat2
        logic rv2_q, rerr2_q;
        logic [DATA_WIDTH-1:0] data2_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rv2_q   <= 1'b0;
                rerr2_q <= 1'b0;
                data2_q <= '0;
            end else begin
                rv2_q   <= rv1_q;
                rerr2_q <= rerr1_q;
                if (rv1_q) begin
                    data2_q <= arr_rdata;
                end
            end
        end

        assign rd_valid = rv2_q;
        assign rd_err   = rerr2_q;
        assign data_out = data2_q;
    end

    assign rvalid = rd_valid;
    // A write error and a delayed read error can land on the same cycle.
    assign err    = werr_q || rd_err;

endmodule

// File: tb/tb_param_mem.sv
// Randomised bench for param_mem: two configurations driven by shared stimulus and
// checked every cycle against a scoreboard of scheduled responses.
module tb_param_mem;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [4:0] addr = '0;
    logic [7:0] data_in = '0;

    logic [7:0] dout_w [2];
    logic       ready_w [2];
    logic       rvalid_w [2];
    logic       err_w [2];
    logic       busy_w [2];

    always #5 clk = ~clk;

    param_mem #(
        .CLEAR_VALUE (8'hA5)
    ) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .read     (read),
        .write    (write),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (dout_w[0]),
        .ready    (ready_w[0]),
        .rvalid   (rvalid_w[0]),
        .err      (err_w[0]),
        .busy     (busy_w[0])
    );

    param_mem #(
        .DEPTH        (20),
        .READ_LATENCY (2),
        .CLEAR_VALUE  (8'h3C)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .read     (read),
        .write    (write),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (dout_w[1]),
        .ready    (ready_w[1]),
        .rvalid   (rvalid_w[1]),
        .err      (err_w[1]),
        .busy     (busy_w[1])
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int unsigned m_depth [2] = '{32, 20};
    int unsigned m_lat   [2] = '{1, 2};
    logic [7:0]  m_cv    [2] = '{8'hA5, 8'h3C};

    logic [7:0]  m_mem [2][32];
    int unsigned clear_left [2];
    logic [7:0]  exp_dout [2];
    logic        exp_rv [2];
    logic        exp_err [2];
    // Responses scheduled by output cycle, indexed modulo 4.
    logic        s_rv [2][4];
    logic        s_err [2][4];
    logic [7:0]  s_data [2][4];
    int unsigned edge_n = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic model_edge(input int d, input logic r, input logic rd, input logic wr,
                              input logic [4:0] a, input logic [7:0] din);
        int unsigned slot;
        bit oor;
        slot = edge_n % 4;
        oor  = (int'(a) >= int'(m_depth[d]));
        if (r) begin
            clear_left[d] = m_depth[d];
            for (int i = 0; i < 4; i++) begin
                s_rv[d][i]   = 1'b0;
                s_err[d][i]  = 1'b0;
                s_data[d][i] = '0;
            end
            exp_dout[d] = '0;
            exp_rv[d]   = 1'b0;
            exp_err[d]  = 1'b0;
            return;
        end
        if (clear_left[d] > 0) begin
            m_mem[d][m_depth[d] - clear_left[d]] = m_cv[d];
            clear_left[d]--;
        end else if (rd != wr) begin
            if (wr) begin
                if (oor) s_err[d][slot] = 1'b1;
                else     m_mem[d][a] = din;
            end else begin
                int unsigned rs;
                rs = (edge_n + m_lat[d] - 1) % 4;
                s_rv[d][rs]   = 1'b1;
                s_err[d][rs]  = s_err[d][rs] | oor;
                s_data[d][rs] = oor ? 8'h00 : m_mem[d][a];
            end
        end
        exp_rv[d]  = s_rv[d][slot];
        exp_err[d] = s_err[d][slot];
        if (s_rv[d][slot]) exp_dout[d] = s_data[d][slot];
        s_rv[d][slot]  = 1'b0;
        s_err[d][slot] = 1'b0;
    endtask

    task automatic cyc(input logic r, input logic rd, input logic wr,
                       input logic [4:0] a, input logic [7:0] din);
        rst     = r;
        read    = rd;
        write   = wr;
        addr    = a;
        data_in = din;
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_edge(d, r, rd, wr, a, din);
        edge_n++;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("ready[%0d]", d), 32'(ready_w[d]), 32'(clear_left[d] == 0));
            check_eq($sformatf("busy[%0d]", d), 32'(busy_w[d]), 32'(clear_left[d] != 0));
            check_eq($sformatf("rvalid[%0d]", d), 32'(rvalid_w[d]), 32'(exp_rv[d]));
            check_eq($sformatf("err[%0d]", d), 32'(err_w[d]), 32'(exp_err[d]));
            check_eq($sformatf("data_out[%0d]", d), 32'(dout_w[d]), 32'(exp_dout[d]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    endtask

    initial begin
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        idle(34);
        // Clear pattern visible at both ends and in the middle.
        cyc(1'b0, 1'b1, 1'b0, 5'd0, 8'd0);
        cyc(1'b0, 1'b1, 1'b0, 5'd17, 8'd0);
        cyc(1'b0, 1'b1, 1'b0, 5'd31, 8'd0);
        idle(3);
        // Write then read on the next cycle.
        cyc(1'b0, 1'b0, 1'b1, 5'd5, 8'd200);
        cyc(1'b0, 1'b1, 1'b0, 5'd5, 8'd0);
        idle(3);
        // Back-to-back reads.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 5'(i), 8'((i + 1) * 10));
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 5'(i), 8'd0);
        idle(3);
        // Both strobes high is idle.
        cyc(1'b0, 1'b1, 1'b1, 5'd7, 8'd99);
        cyc(1'b0, 1'b1, 1'b0, 5'd7, 8'd0);
        idle(3);
        // Out-of-range write and read (only out of range for the DEPTH=20 instance).
        cyc(1'b0, 1'b0, 1'b1, 5'd25, 8'd55);
        cyc(1'b0, 1'b1, 1'b0, 5'd5, 8'd0);
        cyc(1'b0, 1'b1, 1'b0, 5'd25, 8'd0);
        idle(3);
        // Reset right after an accepted read drops the response.
        cyc(1'b0, 1'b1, 1'b0, 5'd2, 8'd0);
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
        idle(36);
        for (int i = 0; i < 3000; i++) begin
            logic r, rd, wr;
            int unsigned op;
            r  = ($urandom_range(0, 249) == 0);
            op = $urandom_range(0, 7);
            rd = (op inside {1, 2, 3, 7});
            wr = (op inside {4, 5, 6, 7});
            cyc(r, rd, wr, 5'($urandom_range(0, 31)), 8'($urandom));
        end
        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
